// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider that produces one quotient bit per clock.
// Handshakes are valid/ready on both sides. Each trial subtract uses a 4-bit group borrow-lookahead.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int NG = WIDTH / 4;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_dq;          // dividend shifts out at the MSB, quotient bits shift in at the LSB
  logic [WIDTH-1:0] r_v;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_dq_next;

  // NOTE: state and datapath flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: default assignment first, so no path through the case leaves w_state_next unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_next = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // R stays below V after every iteration. Its extra MSB therefore exists only in the trial value.
  assign w_trial = {r_r, r_dq[WIDTH-1]};

  always_comb begin : borrow_lookahead
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] bin;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gb;
    g   = ~w_trial[WIDTH-1:0] & r_v;
    p   = ~(w_trial[WIDTH-1:0] ^ r_v);
    gg  = '0;
    gp  = '0;
    gb  = '0;
    bin = '0;
    for (int k = 0; k < NG; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (&p[4*k+1 +: 3] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    for (int k = 0; k < NG; k++) begin
      gb[k+1] = gg[k] | (gp[k] & gb[k]);
    end
    for (int k = 0; k < NG; k++) begin
      bin[4*k]   = gb[k];
      bin[4*k+1] = g[4*k] | (p[4*k] & gb[k]);
      bin[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gb[k]);
      bin[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                 | (&p[4*k +: 3] & gb[k]);
    end
    w_diff   = w_trial[WIDTH-1:0] ^ r_v ^ bin;
    w_borrow = ~w_trial[WIDTH] & gb[NG];
  end

  assign w_r_next  = w_borrow ? w_trial[WIDTH-1:0] : w_diff;
  assign w_dq_next = {r_dq[WIDTH-2:0], ~w_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dq        <= '0;
      r_v         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dq  <= dividend;
            r_v   <= divisor;
            r_r   <= '0;
            r_cnt <= CW'(WIDTH - 1);
            r_dbz <= (divisor == '0);
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
            end
          end
        end
        S_CALC: begin
          r_r  <= w_r_next;
          r_dq <= w_dq_next;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_quotient  <= w_dq_next;
            r_remainder <= w_r_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed corner cases plus randomized operations.
// Every result is checked against a plain-arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_accepts = 0;
  int   n_results = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d);
    exp_t e;
    e.n = n;
    e.d = d;
    if (d == 0) begin
      e.q = '1;
      e.r = n;
      e.z = 1'b1;
    end else begin
      e.q = n / d;
      e.r = n % d;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Present operands and return at the negedge right after the accepting posedge.
  task automatic start(input logic [W-1:0] n, input logic [W-1:0] d);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    sb.push_back(model(n, d));
    n_accepts++;
  endtask

  // Number of posedges after the accepting edge until out_valid is seen.
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic check_result(input string tag, input int cycles);
    exp_t        e;
    logic [63:0] recon;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    n_results++;
    check({tag, "_latency"}, 64'(cycles), (e.d == 0) ? 64'd0 : 64'(W));
    check({tag, "_q"}, quotient, e.q);
    check({tag, "_r"}, remainder, e.r);
    check({tag, "_dbz"}, div_by_zero, e.z);
    if (e.d != 0) begin
      recon = 64'(quotient) * 64'(e.d) + 64'(remainder);
      check({tag, "_identity"}, recon, 64'(e.n));
      check({tag, "_r_lt_d"}, remainder < e.d, 1'b1);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, in_ready, 1'b1);
    check({tag, "_out_valid_after"}, out_valid, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] n, input logic [W-1:0] d);
    int cyc;
    start(n, d);
    check({tag, "_busy"}, busy, 1'b1);
    wait_result(cyc);
    check_result(tag, cyc);
    consume(tag);
  endtask

  initial begin
    int          cyc;
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    int          mode;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div_100_7", 100, 7);
    run_op("div_5_9", 5, 9);
    run_op("div_max_1", 32'hFFFF_FFFF, 1);
    run_op("div_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_1234_0", 1234, 0);
    run_op("div_10_3", 10, 3);

    // Result must hold under backpressure while new operands are offered and ignored.
    start(50, 6);
    wait_result(cyc);
    check_result("bp_first", cyc);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      dividend = 77;
      divisor  = 5;
      @(negedge clk);
      check("bp_hold_q", quotient, 8);
      check("bp_hold_r", remainder, 2);
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    sb.push_back(model(77, 5));
    n_accepts++;
    wait_result(cyc);
    check_result("bp_second", cyc);
    consume("bp_second");

    // Asynchronous reset in the middle of an operation.
    start(1000, 3);
    repeat (16) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    void'(sb.pop_back());
    n_accepts--;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("midrst_no_result", out_valid, 0);
    end
    run_op("div_81_9", 81, 9);

    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      n    = $urandom;
      mode = $urandom_range(0, 49);
      if (mode == 0)      d = '0;
      else if (mode < 15) d = W'($urandom_range(1, 255));
      else if (mode < 20) d = n + W'($urandom_range(0, 3));
      else                d = $urandom >> $urandom_range(0, 31);
      if (d == 0 && mode != 0) d = 1;
      start(n, d);
      wait_result(cyc);
      hq = quotient;
      hr = remainder;
      check_result("rnd", cyc);
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b1;
        dividend = $urandom;
        divisor  = $urandom;
        @(negedge clk);
        check("rnd_hold_q", quotient, hq);
        check("rnd_hold_r", remainder, hr);
        check("rnd_hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      consume("rnd");
    end

    check("sb_drained", 64'(sb.size()), 0);
    check("results_eq_accepts", 64'(n_results), 64'(n_accepts));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
